// File: rtl/mdio_master.sv
// Clause 22 MDIO management master: queued read/write frames on MDC/MDIO.
// Optional automatic BMSR link polling is compiled in with `define MDIO_POLL_EN.
//
// Ports:
//   CLK, RST           system clock, asynchronous active-low reset
//   cmd_*              command request (valid/ready), write flag, PHY/reg, data
//   rsp_valid          one-cycle completion pulse
//   rsp_rdata/rsp_err  read data (held) and no-PHY flag (valid with rsp_valid)
//   busy               frame in progress
//   mdc                management clock
//   mdio_in/out/oen    pin sample, drive value, drive enable (0 = drive)
//   poll_phy, link_up, poll_busy   only with MDIO_POLL_EN
module mdio_master #(
  parameter int CLK_DIV      = 20,
  parameter int PREAMBLE_LEN = 32
`ifdef MDIO_POLL_EN
  ,
  parameter int POLL_INTERVAL = 1000000
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oen
`ifdef MDIO_POLL_EN
  ,
  input  logic [4:0]  poll_phy,
  output logic        link_up,
  output logic        poll_busy
`endif
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [5:0] LAST = 6'(PREAMBLE_LEN + 31);
  localparam logic [6:0] PRE7 = 7'(PREAMBLE_LEN);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // Frame after the preamble. For reads the bits from TA on are 1 so the
  // released pin idles high.
  function automatic logic [31:0] mk_frame(
    input logic        wr,
    input logic [4:0]  phy,
    input logic [4:0]  ra,
    input logic [15:0] wd
  );
    if (wr) mk_frame = {4'b0101, phy, ra, 2'b10, wd};
    else    mk_frame = {4'b0110, phy, ra, 2'b11, 16'hFFFF};
  endfunction

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [5:0]    bit_q, bit_d;
  logic [31:0]   frame_q, frame_d;
  logic          write_q, write_d;

  logic          mdc_q, out_q, oen_q;
  logic          err_q, rerr_q;
  logic [15:0]   sh_q, rdata_q;

  logic          load, rise, fall, fin;
  logic          poll_cur;
  logic          pin_out, pin_oen;
  logic [6:0]    nfi7, cfi7;
  logic          ta2, dat;

`ifdef MDIO_POLL_EN
  localparam int PCW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(POLL_INTERVAL - 1);

  logic [PCW-1:0] pcnt_q;
  logic           poll_q, link_q;
  logic           poll_due, poll_go;

  assign poll_due  = (pcnt_q == PC_LAST);
  assign poll_cur  = poll_q;
  assign link_up   = link_q;
  assign poll_busy = poll_q;
`else
  assign poll_cur = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    write_d = write_q;
    load    = 1'b0;
    rise    = 1'b0;
    fall    = 1'b0;
    fin     = 1'b0;
`ifdef MDIO_POLL_EN
    poll_go = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        bit_d   = '0;
        if (cmd_valid) begin
          load    = 1'b1;
          write_d = cmd_write;
          frame_d = mk_frame(cmd_write, cmd_phy,
                             cmd_reg, cmd_wdata);
          state_d = SHIFT;
        end
`ifdef MDIO_POLL_EN
        else if (poll_due) begin
          load    = 1'b1;
          poll_go = 1'b1;
          write_d = 1'b0;
          frame_d = mk_frame(1'b0, poll_phy,
                             5'd1, 16'h0000);
          state_d = SHIFT;
        end
`endif
      end
      SHIFT: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (!mdc_q) begin
            rise = 1'b1;
          end else if (bit_q == LAST) begin
            fin     = 1'b1;
            state_d = DONE;
          end else begin
            fall  = 1'b1;
            bit_d = bit_q + 6'd1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Index into the post-preamble frame; bit 6 set means still in preamble.
  assign nfi7 = {1'b0, bit_d} - PRE7;
  assign cfi7 = {1'b0, bit_q} - PRE7;

  assign pin_out = nfi7[6] ? 1'b1 : frame_d[~nfi7[4:0]];
  assign pin_oen = !write_d && !nfi7[6] &&
                   (nfi7[5:0] >= 6'd14);

  assign ta2 = !cfi7[6] && (cfi7[5:0] == 6'd15);
  assign dat = !cfi7[6] && (cfi7[5:4] == 2'b01);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mdc_q   <= 1'b0;
      out_q   <= 1'b1;
      oen_q   <= 1'b1;
      err_q   <= 1'b0;
      rerr_q  <= 1'b0;
      sh_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (load || fall) begin
        mdc_q <= 1'b0;
        out_q <= pin_out;
        oen_q <= pin_oen;
      end
      if (rise) begin
        mdc_q <= 1'b1;
        if (ta2) err_q <= mdio_in;
        if (dat) sh_q <= {sh_q[14:0], mdio_in};
      end
      if (fin) begin
        mdc_q <= 1'b0;
        out_q <= 1'b1;
        oen_q <= 1'b1;
        if (!poll_cur) begin
          rerr_q <= !write_q && err_q;
          if (!write_q) rdata_q <= sh_q;
        end
      end
    end
  end

`ifdef MDIO_POLL_EN
  // Counter only advances in IDLE; once due it waits for a free IDLE cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pcnt_q <= '0;
      poll_q <= 1'b0;
      link_q <= 1'b0;
    end else begin
      if (poll_go) begin
        poll_q <= 1'b1;
        pcnt_q <= '0;
      end else if (state_q == IDLE && !poll_due) begin
        pcnt_q <= pcnt_q + 1'b1;
      end
      if (state_q == DONE) poll_q <= 1'b0;
      if (fin && poll_q) link_q <= !err_q && sh_q[2];
    end
  end
`endif

  assign cmd_ready = (state_q == IDLE);
  assign busy      = !cmd_ready;
  assign rsp_valid = (state_q == DONE) && !poll_cur;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;
  assign mdc       = mdc_q;
  assign mdio_out  = out_q;
  assign mdio_oen  = oen_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: two instances (32-bit and suppressed
// preamble), table of frames plus hold-valid and mid-frame reset sequences.
module tb_mdio_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  vld = 2'b00;
  logic        wr = 1'b0;
  logic [4:0]  phy = '0;
  logic [4:0]  ra = '0;
  logic [15:0] wd = '0;
  logic [1:0]  min = 2'b11;

  logic [1:0]  rdy, rv, er, bz, mc, mo, moe;
  logic [15:0] rd [2];
`ifdef MDIO_POLL_EN
  logic [1:0]  lu, pb;
`endif

  mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(32)) u_a (
    .CLK(clk), .RST(rst_n),
    .cmd_valid(vld[0]), .cmd_ready(rdy[0]),
    .cmd_write(wr), .cmd_phy(phy), .cmd_reg(ra),
    .cmd_wdata(wd),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]),
    .rsp_err(er[0]), .busy(bz[0]), .mdc(mc[0]),
    .mdio_in(min[0]), .mdio_out(mo[0]),
    .mdio_oen(moe[0])
`ifdef MDIO_POLL_EN
    , .poll_phy(5'd0), .link_up(lu[0]),
    .poll_busy(pb[0])
`endif
  );

  mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(0)) u_b (
    .CLK(clk), .RST(rst_n),
    .cmd_valid(vld[1]), .cmd_ready(rdy[1]),
    .cmd_write(wr), .cmd_phy(phy), .cmd_reg(ra),
    .cmd_wdata(wd),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]),
    .rsp_err(er[1]), .busy(bz[1]), .mdc(mc[1]),
    .mdio_in(min[1]), .mdio_out(mo[1]),
    .mdio_oen(moe[1])
`ifdef MDIO_POLL_EN
    , .poll_phy(5'd0), .link_up(lu[1]),
    .poll_busy(pb[1])
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    bit        s;
    bit        wr;
    bit [4:0]  phy;
    bit [4:0]  ra;
    bit [15:0] wd;
    bit        ta;
    bit [15:0] din;
    bit [63:0] es;
    bit [63:0] eo;
    int        lat;
    bit [15:0] erd;
    bit        eerr;
  } row_t;

  row_t tbl [7];

  function automatic logic phy_bit(input row_t r,
                                   input int fi);
    if (fi == 15) return r.ta;
    if (fi >= 16 && fi <= 31) return r.din[31 - fi];
    return 1'b1;
  endfunction

  task automatic run_row(input row_t r, input bit armed);
    int n, pre, b, ph, lat, badmdc, badrdy, nrv;
    logic [63:0] st, oe;
    logic [15:0] crd;
    logic        cer;
    n = r.s ? 32 : 64;
    pre = r.s ? 0 : 32;
    lat = -1; badmdc = 0; badrdy = 0; nrv = 0;
    st = '0; oe = '0; crd = 'x; cer = 1'bx;
    if (!armed) begin
      @(negedge clk);
      wr = r.wr; phy = r.phy; ra = r.ra; wd = r.wd;
      vld[r.s] = 1'b1;
      min[r.s] = 1'b1;
    end
    chk("ready_before", rdy[r.s], 1);
    @(posedge clk);
    for (int c = 1; c <= 4 * n + 4; c++) begin
      @(negedge clk);
      if (c == 1) vld[r.s] = 1'b0;
      if (c <= 4 * n) begin
        b = (c - 1) / 4;
        ph = (c - 1) % 4;
        if (ph == 0) begin
          st = {st[62:0], mo[r.s]};
          oe = {oe[62:0], moe[r.s]};
          min[r.s] = phy_bit(r, b - pre);
        end
        if (mc[r.s] !== (ph >= 2)) badmdc++;
        if (rdy[r.s] !== 1'b0) badrdy++;
      end
      if (rv[r.s] === 1'b1) begin
        nrv++;
        if (lat < 0) begin
          lat = c;
          crd = rd[r.s];
          cer = er[r.s];
          chk("mdc_done", mc[r.s], 0);
        end
      end
      if (c == 4 * n + 2)
        chk("ready_after", rdy[r.s], 1);
    end
    min[r.s] = 1'b1;
    chk("stream", st, r.es);
    chk("oen", oe, r.eo);
    chk("latency", 64'(lat), 64'(r.lat));
    chk("rsp_count", 64'(nrv), 1);
    chk("rdata", crd, r.erd);
    chk("rsp_err", cer, r.eerr);
    chk("mdc_wave", 64'(badmdc), 0);
    chk("busy_ready", 64'(badrdy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, badrdy, nrv;
    row_t rb;

    tbl[0] = '{0, 1, 5'd1, 5'd0, 16'h3100, 1, 16'hFFFF,
               64'hFFFFFFFF_50823100, 64'h0, 257,
               16'h0000, 0};
    tbl[1] = '{0, 0, 5'd1, 5'd2, 16'h0000, 0, 16'h2000,
               64'hFFFFFFFF_608BFFFF, 64'h3FFFF, 257,
               16'h2000, 0};
    tbl[2] = '{0, 0, 5'd31, 5'd1, 16'h0000, 1, 16'hFFFF,
               64'hFFFFFFFF_6F87FFFF, 64'h3FFFF, 257,
               16'hFFFF, 1};
    tbl[3] = '{0, 1, 5'd5, 5'd31, 16'h0001, 1, 16'hFFFF,
               64'hFFFFFFFF_52FE0001, 64'h0, 257,
               16'hFFFF, 0};
    tbl[4] = '{1, 0, 5'd1, 5'd3, 16'h0000, 0, 16'h5C90,
               64'h00000000_608FFFFF, 64'h3FFFF, 129,
               16'h5C90, 0};
    tbl[5] = '{0, 0, 5'd0, 5'd16, 16'h0000, 0, 16'hA5A5,
               64'hFFFFFFFF_6043FFFF, 64'h3FFFF, 257,
               16'hA5A5, 0};
    tbl[6] = '{1, 1, 5'd26, 5'd21, 16'hBEEF, 1, 16'hFFFF,
               64'h00000000_5D56BEEF, 64'h0, 129,
               16'h5C90, 0};
    rb = '{0, 1, 5'd3, 5'd5, 16'hABCD, 1, 16'hFFFF,
           64'hFFFFFFFF_5196ABCD, 64'h0, 257,
           16'hA5A5, 0};

    // reset state
    #12;
    chk("rst_ready", rdy, 2'b11);
    chk("rst_busy", bz, 2'b00);
    chk("rst_rv", rv, 2'b00);
    chk("rst_rdata", rd[0], 0);
    chk("rst_err", er, 2'b00);
    chk("rst_mdc", mc, 2'b00);
    chk("rst_out", mo, 2'b11);
    chk("rst_oen", moe, 2'b11);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_mdc", mc, 2'b00);

    foreach (tbl[i]) run_row(tbl[i], 0);

    // hold cmd_valid across a frame while fields change
    @(negedge clk);
    wr = 1'b1; phy = 5'd2; ra = 5'd4; wd = 16'h1234;
    vld[0] = 1'b1;
    @(posedge clk);
    lat = -1; badrdy = 0;
    for (int c = 1; c <= 258; c++) begin
      @(negedge clk);
      if (c == 1) begin
        phy = 5'd3; ra = 5'd5; wd = 16'hABCD;
      end
      if (c <= 257 && rdy[0] !== 1'b0) badrdy++;
      if (rv[0] === 1'b1 && lat < 0) lat = c;
    end
    chk("hold_noaccept", 64'(badrdy), 0);
    chk("hold_lat", 64'(lat), 257);
    run_row(rb, 1);

    // async reset at bit 40 of a read
    @(negedge clk);
    wr = 1'b0; phy = 5'd1; ra = 5'd2;
    vld[0] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 163; c++) begin
      @(negedge clk);
      if (c == 1) vld[0] = 1'b0;
    end
    chk("mid_mdc_hi", mc[0], 1);
    chk("mid_busy", bz[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mdc", mc[0], 0);
    chk("abort_oen", moe[0], 1);
    chk("abort_out", mo[0], 1);
    chk("abort_ready", rdy[0], 1);
    chk("abort_busy", bz[0], 0);
    chk("abort_rdata", rd[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nrv = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (rv[0] !== 1'b0) nrv++;
    end
    chk("abort_norsp", 64'(nrv), 0);
    chk("abort_idle", rdy[0], 1);
    run_row(tbl[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
